axil_ctrl_responder: RTL and testbench
======================================

Name: axil_ctrl_responder

Overview:
- AXI4-Lite subordinate (responder) terminating transactions issued by the AXI master on the FPGA side.
- Provides a small memory-mapped control/status window: RW control register, RW scratch register, RO status, RO ID.
- Sits behind the interconnect at a 4 KB window of the 0x6000_0000 aperture.
- Drives control bits into the user project and reports back its status.

Parameters:
- ADDR_WIDTH, 12, byte-address bits decoded (4 KB window).
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- CTRL_WIDTH, 2, number of implemented CTRL bits driven on ctrl_o.
- ID_VALUE, 32'h4653_4943, constant returned by the ID register.

Ports:
- axi_clk  in  1  sole clock.
- axi_reset_n  in  1  asynchronous active-low reset.
- s_awaddr  in  ADDR_WIDTH  write address.
- s_awvalid  in  1, s_awready  out  1  write address handshake.
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte strobes.
- s_wvalid  in  1, s_wready  out  1  write data handshake.
- s_bresp  out  2  write response.
- s_bvalid  out  1, s_bready  in  1  write response handshake.
- s_araddr  in  ADDR_WIDTH  read address.
- s_arvalid  in  1, s_arready  out  1  read address handshake.
- s_rdata  out  32  read data.
- s_rresp  out  2  read response.
- s_rvalid  out  1, s_rready  in  1  read data handshake.
- ctrl_o  out  CTRL_WIDTH  CTRL[CTRL_WIDTH-1:0].
- status_i  in  32  live status, sampled on read.

Behaviour:
- Reset (async assert, sync release): all outputs 0, including ready/valid signals, bresp, rresp, rdata, ctrl_o, CTRL, SCRATCH and the internal latches.
- Register map, word-aligned; addr[1:0] ignored:
  - 0x000 CTRL: RW; bits above CTRL_WIDTH read 0.
  - 0x004 SCRATCH: RW, 32 bits.
  - 0x008 STATUS: RO, returns status_i.
  - 0x00C ID: RO, returns ID_VALUE.
  - All other offsets: bresp/rresp = 2'b10 (SLVERR); rdata = 0; no state change.
  - Write to a RO register: SLVERR, no effect.
- Write path, one outstanding transaction; states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP:
  - s_awready = 1 in W_IDLE and W_HAVE_W.
  - s_wready = 1 in W_IDLE and W_HAVE_AW.
  - AW and W may arrive in the same cycle or either order; each is latched on its handshake.
  - When both are latched (cycle N), go to W_RESP at N+1: register updated per s_wstrb, s_bvalid = 1, bresp set.
  - s_bvalid holds with bresp stable until s_bready; on the handshake cycle go to W_IDLE, bvalid = 0 next cycle.
  - Both ready signals are 0 in W_RESP.
  - wstrb = 0: OKAY response, no byte changed.
- Read path, independent of write; states R_IDLE, R_RESP:
  - s_arready = 1 only in R_IDLE.
  - AR handshake at cycle N: at N+1 s_rvalid = 1, with s_rdata/s_rresp holding values decoded from register contents at N.
  - rdata/rresp stay stable while rvalid = 1 and rready = 0; rvalid clears the cycle after the rready handshake.
- Same-cycle read and write commit to the same register: the read returns the pre-write value.
- ctrl_o is registered; it changes the cycle after the CTRL write commits, together with bvalid.
- Reset mid-transaction: outstanding AW/W/B/R state is discarded; the master must reissue.

Test Plan:
- Read 0x000 after reset -> rvalid 1 cycle after AR handshake, rdata 0, rresp 00; then write 0x000 = 1 -> bresp 00, ctrl_o = 2'b01; write 3 -> ctrl_o = 2'b11, readback 3.
- Write data before address: W handshake 3 cycles before AW to SCRATCH = 0x0000_0011 -> bvalid 1 cycle after AW; read returns 0x11; swap order, same result.
- Byte strobes: SCRATCH = 0xAABBCCDD, then write 0x11223344 with wstrb 4'b0101 -> readback 0xAA22CC44.
- Backpressure: hold bready/rready low 10 cycles -> bvalid/rvalid and data held stable; awready, wready and arready stay 0 on the stalled channel.
- Error decode: write 0x008 or 0x100 -> bresp 10, status unchanged; read 0x100 -> rresp 10, rdata 0; read 0x00C -> ID_VALUE; read 0x008 with status_i = 0x5A5A -> 0x5A5A.
- Reset mid-write (AW latched, W pending), then release -> all valids 0, CTRL 0, next full write completes normally.

Source files
------------

// File: rtl/axil_ctrl_responder.sv
// AXI4-Lite responder exposing a small control/status window: CTRL (RW), SCRATCH (RW),
// STATUS (RO, live input) and ID (RO constant). One outstanding write and one read in flight.
module axil_ctrl_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 2,
  parameter logic [31:0] ID_VALUE   = 32'h4653_4943
) (
  input  logic                    axi_clk,
  input  logic                    axi_reset_n,

  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,

  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,

  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,

  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,

  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,

  output logic [CTRL_WIDTH-1:0]   ctrl_o,
  input  logic [DATA_WIDTH-1:0]   status_i
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned IdxW  = ADDR_WIDTH - 2;

  localparam logic [IdxW-1:0] IdxCtrl    = IdxW'(0);
  localparam logic [IdxW-1:0] IdxScratch = IdxW'(1);
  localparam logic [IdxW-1:0] IdxStatus  = IdxW'(2);
  localparam logic [IdxW-1:0] IdxId      = IdxW'(3);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {
    WIdle,
    WHaveAw,
    WHaveW,
    WResp
  } w_state_e;

  typedef enum logic {
    RIdle,
    RResp
  } r_state_e;

  function automatic logic [DATA_WIDTH-1:0] apply_strb(input logic [DATA_WIDTH-1:0] old_val,
                                                       input logic [DATA_WIDTH-1:0] new_val,
                                                       input logic [StrbW-1:0]      strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(StrbW); i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Word-aligned map: the byte-offset bits play no part in decode.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s_awaddr[1:0], s_araddr[1:0]};

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic                  active_q;
  logic [IdxW-1:0]       aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]      wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [IdxW-1:0]       wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data, rd_val;
  logic [StrbW-1:0]      wr_strb;
  logic                  rd_err;

  // Readies stay low for the first cycle out of reset so every output is 0 during reset.
  assign s_awready = active_q & ((w_state_q == WIdle) | (w_state_q == WHaveW));
  assign s_wready  = active_q & ((w_state_q == WIdle) | (w_state_q == WHaveAw));
  assign s_arready = active_q & (r_state_q == RIdle);

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign ar_hs = s_arvalid & s_arready;

  // The commit cycle uses the latched half of the transaction plus whatever arrives now.
  assign wr_idx  = (w_state_q == WHaveAw) ? aw_idx_q : s_awaddr[ADDR_WIDTH-1:2];
  assign wr_data = (w_state_q == WHaveW) ? wdata_q : s_wdata;
  assign wr_strb = (w_state_q == WHaveW) ? wstrb_q : s_wstrb;
  assign rd_idx  = s_araddr[ADDR_WIDTH-1:2];

  always_comb begin
    w_state_d = w_state_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    commit    = 1'b0;

    if (aw_hs) aw_idx_d = s_awaddr[ADDR_WIDTH-1:2];
    if (w_hs) begin
      wdata_d = s_wdata;
      wstrb_d = s_wstrb;
    end

    unique case (w_state_q)
      WIdle: begin
        if (aw_hs && w_hs) commit = 1'b1;
        else if (aw_hs)    w_state_d = WHaveAw;
        else if (w_hs)     w_state_d = WHaveW;
      end
      WHaveAw: if (w_hs) commit = 1'b1;
      WHaveW:  if (aw_hs) commit = 1'b1;
      WResp: begin
        if (s_bready) begin
          w_state_d = WIdle;
          bvalid_d  = 1'b0;
        end
      end
      default: w_state_d = WIdle;
    endcase

    if (commit) begin
      w_state_d = WResp;
      bvalid_d  = 1'b1;
    end
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    bresp_d   = bresp_q;
    if (commit) begin
      case (wr_idx)
        IdxCtrl: begin
          ctrl_d  = CTRL_WIDTH'(apply_strb(DATA_WIDTH'(ctrl_q), wr_data, wr_strb));
          bresp_d = RespOkay;
        end
        IdxScratch: begin
          scratch_d = apply_strb(scratch_q, wr_data, wr_strb);
          bresp_d   = RespOkay;
        end
        default: bresp_d = RespSlvErr;
      endcase
    end
  end

  // Decodes from current register contents, so a same-cycle write is not yet visible.
  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (rd_idx)
      IdxCtrl:    rd_val = DATA_WIDTH'(ctrl_q);
      IdxScratch: rd_val = scratch_q;
      IdxStatus:  rd_val = status_i;
      IdxId:      rd_val = DATA_WIDTH'(ID_VALUE);
      default:    rd_err = 1'b1;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          r_state_d = RResp;
          rvalid_d  = 1'b1;
          rdata_d   = rd_val;
          rresp_d   = rd_err ? RespSlvErr : RespOkay;
        end
      end
      RResp: begin
        if (s_rready) begin
          r_state_d = RIdle;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      active_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      scratch_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      active_q  <= 1'b1;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
    end
  end

  assign s_bvalid = bvalid_q;
  assign s_bresp  = bresp_q;
  assign s_rvalid = rvalid_q;
  assign s_rresp  = rresp_q;
  assign s_rdata  = rdata_q;
  assign ctrl_o   = ctrl_q;

endmodule

// File: tb/tb_axil_ctrl_responder.sv
// Directed self-checking bench for axil_ctrl_responder: register map, handshake ordering,
// byte strobes, backpressure, error decode and reset in the middle of a write.
module tb_axil_ctrl_responder;

  localparam logic [31:0] IdVal  = 32'h4653_4943;
  localparam logic [1:0]  Okay   = 2'b00;
  localparam logic [1:0]  SlvErr = 2'b10;

  logic        axi_clk = 1'b0;
  logic        axi_reset_n = 1'b0;
  logic [11:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [11:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [1:0]  ctrl_o;
  logic [31:0] status_i = '0;

  int errors = 0;
  int checks = 0;

  axil_ctrl_responder dut (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .s_awaddr    (s_awaddr),
    .s_awvalid   (s_awvalid),
    .s_awready   (s_awready),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_wvalid    (s_wvalid),
    .s_wready    (s_wready),
    .s_bresp     (s_bresp),
    .s_bvalid    (s_bvalid),
    .s_bready    (s_bready),
    .s_araddr    (s_araddr),
    .s_arvalid   (s_arvalid),
    .s_arready   (s_arready),
    .s_rdata     (s_rdata),
    .s_rresp     (s_rresp),
    .s_rvalid    (s_rvalid),
    .s_rready    (s_rready),
    .ctrl_o      (ctrl_o),
    .status_i    (status_i)
  );

  always #5 axi_clk = ~axi_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  // AW and W offered together; stall holds bready low to exercise backpressure.
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er, input int stall);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int n = 0;
    s_awaddr  = a;
    s_wdata   = d;
    s_wstrb   = s;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      if (s_awvalid && s_awready) aw_done = 1'b1;
      if (s_wvalid && s_wready) w_done = 1'b1;
      tick();
      n++;
      if (aw_done) s_awvalid = 1'b0;
      if (w_done) s_wvalid = 1'b0;
    end
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    check_eq("wr_handshake", 32'(aw_done && w_done), 32'd1);
    check_eq("wr_bvalid", 32'(s_bvalid), 32'd1);
    check_eq("wr_bresp", 32'(s_bresp), 32'(er));
    for (int i = 0; i < stall; i++) begin
      tick();
      check_eq("wr_stall_bvalid", 32'(s_bvalid), 32'd1);
      check_eq("wr_stall_bresp", 32'(s_bresp), 32'(er));
      check_eq("wr_stall_awready", 32'(s_awready), 32'd0);
      check_eq("wr_stall_wready", 32'(s_wready), 32'd0);
    end
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    check_eq("wr_bvalid_clr", 32'(s_bvalid), 32'd0);
  endtask

  // One channel first, gap idle cycles, then the other; bvalid must follow the second.
  task automatic wr_split(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit wfirst, input int gap);
    int n = 0;
    s_awaddr = a;
    s_wdata  = d;
    s_wstrb  = s;
    if (wfirst) s_wvalid = 1'b1;
    else s_awvalid = 1'b1;
    while (!(wfirst ? s_wready : s_awready) && n < 20) begin
      tick();
      n++;
    end
    check_eq("split_first_ready", 32'(wfirst ? s_wready : s_awready), 32'd1);
    tick();
    s_wvalid  = 1'b0;
    s_awvalid = 1'b0;
    check_eq("split_other_ready", 32'(wfirst ? s_awready : s_wready), 32'd1);
    check_eq("split_first_closed", 32'(wfirst ? s_wready : s_awready), 32'd0);
    check_eq("split_no_early_b", 32'(s_bvalid), 32'd0);
    repeat (gap) tick();
    if (wfirst) s_awvalid = 1'b1;
    else s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    check_eq("split_bvalid", 32'(s_bvalid), 32'd1);
    check_eq("split_bresp", 32'(s_bresp), 32'(Okay));
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    check_eq("split_bvalid_clr", 32'(s_bvalid), 32'd0);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] ed, input logic [1:0] er,
                    input int stall);
    int n = 0;
    s_araddr  = a;
    s_arvalid = 1'b1;
    while (!s_arready && n < 20) begin
      tick();
      n++;
    end
    check_eq("rd_arready", 32'(s_arready), 32'd1);
    tick();
    s_arvalid = 1'b0;
    check_eq("rd_rvalid", 32'(s_rvalid), 32'd1);
    check_eq("rd_rdata", s_rdata, ed);
    check_eq("rd_rresp", 32'(s_rresp), 32'(er));
    for (int i = 0; i < stall; i++) begin
      tick();
      check_eq("rd_stall_rvalid", 32'(s_rvalid), 32'd1);
      check_eq("rd_stall_rdata", s_rdata, ed);
      check_eq("rd_stall_rresp", 32'(s_rresp), 32'(er));
      check_eq("rd_stall_arready", 32'(s_arready), 32'd0);
    end
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    check_eq("rd_rvalid_clr", 32'(s_rvalid), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_awready"}, 32'(s_awready), 32'd0);
    check_eq({tag, "_wready"}, 32'(s_wready), 32'd0);
    check_eq({tag, "_arready"}, 32'(s_arready), 32'd0);
    check_eq({tag, "_bvalid"}, 32'(s_bvalid), 32'd0);
    check_eq({tag, "_rvalid"}, 32'(s_rvalid), 32'd0);
    check_eq({tag, "_bresp"}, 32'(s_bresp), 32'd0);
    check_eq({tag, "_rresp"}, 32'(s_rresp), 32'd0);
    check_eq({tag, "_rdata"}, s_rdata, 32'd0);
    check_eq({tag, "_ctrl"}, 32'(ctrl_o), 32'd0);
  endtask

  initial begin
    #12;
    check_idle_outputs("reset");
    tick();
    axi_reset_n = 1'b1;
    tick();

    // Basic CTRL access
    rd(12'h000, 32'h0, Okay, 0);
    wr(12'h000, 32'h1, 4'hF, Okay, 0);
    check_eq("ctrl_after_1", 32'(ctrl_o), 32'h1);
    wr(12'h000, 32'h3, 4'hF, Okay, 0);
    check_eq("ctrl_after_3", 32'(ctrl_o), 32'h3);
    rd(12'h000, 32'h3, Okay, 0);

    // Channel ordering
    wr_split(12'h004, 32'h0000_0011, 4'hF, 1'b1, 2);
    rd(12'h004, 32'h0000_0011, Okay, 0);
    wr(12'h004, 32'h0, 4'hF, Okay, 0);
    wr_split(12'h004, 32'h0000_0033, 4'hF, 1'b0, 2);
    rd(12'h004, 32'h0000_0033, Okay, 0);

    // Byte strobes, including an all-zero strobe and unaligned address bits
    wr(12'h004, 32'hAABB_CCDD, 4'hF, Okay, 0);
    wr(12'h004, 32'h1122_3344, 4'b0101, Okay, 0);
    rd(12'h004, 32'hAA22_CC44, Okay, 0);
    wr(12'h004, 32'hFFFF_FFFF, 4'h0, Okay, 0);
    rd(12'h004, 32'hAA22_CC44, Okay, 0);
    rd(12'h006, 32'hAA22_CC44, Okay, 0);

    // Backpressure on both response channels
    wr(12'h004, 32'h1234_5678, 4'hF, Okay, 10);
    rd(12'h004, 32'h1234_5678, Okay, 10);

    // Same-cycle read and write of SCRATCH: read sees the old value
    fork
      wr(12'h004, 32'h5555_0000, 4'hF, Okay, 0);
      rd(12'h004, 32'h1234_5678, Okay, 0);
    join
    rd(12'h004, 32'h5555_0000, Okay, 0);

    // Error decode and read-only registers
    status_i = 32'h0000_5A5A;
    wr(12'h008, 32'h0000_FFFF, 4'hF, SlvErr, 0);
    rd(12'h008, 32'h0000_5A5A, Okay, 0);
    wr(12'h100, 32'h0, 4'hF, SlvErr, 0);
    check_eq("ctrl_after_badwr", 32'(ctrl_o), 32'h3);
    rd(12'h100, 32'h0, SlvErr, 0);
    rd(12'h00C, IdVal, Okay, 0);
    wr(12'h00C, 32'h0, 4'hF, SlvErr, 0);
    rd(12'h00C, IdVal, Okay, 0);
    rd(12'h004, 32'h5555_0000, Okay, 0);
    status_i = 32'h0000_00A5;
    rd(12'h008, 32'h0000_00A5, Okay, 0);

    // Reset with AW latched and W still pending
    s_awaddr  = 12'h000;
    s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    check_eq("midwr_wready", 32'(s_wready), 32'd1);
    check_eq("midwr_awready", 32'(s_awready), 32'd0);
    axi_reset_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    tick();
    tick();
    axi_reset_n = 1'b1;
    tick();
    check_eq("postrst_bvalid", 32'(s_bvalid), 32'd0);
    check_eq("postrst_ctrl", 32'(ctrl_o), 32'd0);
    rd(12'h004, 32'h0, Okay, 0);
    wr(12'h000, 32'h2, 4'hF, Okay, 0);
    check_eq("postrst_ctrl_wr", 32'(ctrl_o), 32'h2);
    rd(12'h000, 32'h2, Okay, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
